// File: rtl/probe_table_core.sv
// Linear-probing key/value store: 8 slots, one probe per clock, combinational
// BUSY on status from the accept cycle until the registered result appears.
module probe_table_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] hash,
  input  logic [3:0] key,
  input  logic [3:0] val,
  input  logic [1:0] cmd,
  input  logic       go,
  output logic [1:0] status,
  output logic [3:0] out
);
  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_CLEAR} state_e;

  localparam logic [1:0] C_LOOKUP = 2'd0, C_INSERT = 2'd1, C_DELETE = 2'd2, C_CLEAR = 2'd3;
  localparam logic [1:0] ST_OK = 2'd0, ST_NF = 2'd1, ST_FULL = 2'd2, ST_BUSY = 2'd3;

  state_e            state_q, state_d;
  logic              armed_q, armed_d;
  logic [2:0]        p_q, p_d, n_q, n_d, cand_q, cand_d;
  logic              cand_vld_q, cand_vld_d;
  logic [1:0]        cmd_q, cmd_d, status_q, status_d;
  logic [3:0]        key_q, key_d, val_q, val_d, out_q, out_d;

  logic [7:0]        vld_q, tomb_q;
  logic [7:0][3:0]   tkey_q, tval_q;

  logic              we, wvld, wtomb;
  logic [2:0]        widx;
  logic [3:0]        wkey, wval;

  logic accept, s_vld, s_tomb, s_hit, s_empty, last;
  logic [2:0] cand_idx;

  assign accept   = (state_q == S_IDLE) && go && armed_q;
  assign s_vld    = vld_q[p_q];
  assign s_tomb   = tomb_q[p_q];
  assign s_hit    = s_vld && (tkey_q[p_q] == key_q);
  assign s_empty  = !s_vld && !s_tomb;
  assign last     = (n_q == 3'd7);
  // Earliest free slot on the probe path, including the one under the probe now.
  assign cand_idx = cand_vld_q ? cand_q : p_q;

  always_comb begin
    state_d    = state_q;
    armed_d    = go ? (accept ? 1'b0 : armed_q) : 1'b1;
    p_d        = p_q;
    n_d        = n_q;
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
    cmd_d      = cmd_q;
    key_d      = key_q;
    val_d      = val_q;
    status_d   = status_q;
    out_d      = out_q;
    we         = 1'b0;
    widx       = p_q;
    wvld       = 1'b0;
    wtomb      = 1'b0;
    wkey       = 4'd0;
    wval       = 4'd0;
    case (state_q)
      S_IDLE: if (accept) begin
        cmd_d      = cmd;
        key_d      = key;
        val_d      = val;
        n_d        = 3'd0;
        cand_vld_d = 1'b0;
        p_d        = (cmd == C_CLEAR) ? 3'd0 : hash;
        state_d    = (cmd == C_CLEAR) ? S_CLEAR : S_PROBE;
      end
      S_PROBE: begin
        p_d = p_q + 3'd1;
        n_d = n_q + 3'd1;
        if (!cand_vld_q && !s_vld) begin
          cand_vld_d = 1'b1;
          cand_d     = p_q;
        end
        case (cmd_q)
          C_LOOKUP: begin
            if (s_hit) begin
              status_d = ST_OK;  out_d = tval_q[p_q]; state_d = S_IDLE;
            end else if (s_empty || last) begin
              status_d = ST_NF;  out_d = 4'd0;        state_d = S_IDLE;
            end
          end
          C_INSERT: begin
            if (s_hit) begin
              we = 1'b1; widx = p_q; wvld = 1'b1; wkey = key_q; wval = val_q;
              status_d = ST_OK; state_d = S_IDLE;
            end else if (s_empty || (last && (cand_vld_q || !s_vld))) begin
              we = 1'b1; widx = cand_idx; wvld = 1'b1; wkey = key_q; wval = val_q;
              status_d = ST_OK; state_d = S_IDLE;
            end else if (last) begin
              status_d = ST_FULL; state_d = S_IDLE;
            end
          end
          C_DELETE: begin
            if (s_hit) begin
              we = 1'b1; widx = p_q; wtomb = 1'b1; wkey = tkey_q[p_q]; wval = tval_q[p_q];
              status_d = ST_OK; state_d = S_IDLE;
            end else if (s_empty || last) begin
              status_d = ST_NF; state_d = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_CLEAR: begin
        we  = 1'b1;
        p_d = p_q + 3'd1;
        n_d = n_q + 3'd1;
        if (last) begin
          status_d = ST_OK; out_d = 4'd0; state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      armed_q    <= 1'b1;
      p_q        <= 3'd0;
      n_q        <= 3'd0;
      cand_q     <= 3'd0;
      cand_vld_q <= 1'b0;
      cmd_q      <= 2'd0;
      key_q      <= 4'd0;
      val_q      <= 4'd0;
      status_q   <= ST_OK;
      out_q      <= 4'd0;
      vld_q      <= '0;
      tomb_q     <= '0;
      tkey_q     <= '0;
      tval_q     <= '0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      p_q        <= p_d;
      n_q        <= n_d;
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
      cmd_q      <= cmd_d;
      key_q      <= key_d;
      val_q      <= val_d;
      status_q   <= status_d;
      out_q      <= out_d;
      if (we) begin
        vld_q[widx]  <= wvld;
        tomb_q[widx] <= wtomb;
        tkey_q[widx] <= wkey;
        tval_q[widx] <= wval;
      end
    end
  end

  assign status = ((state_q != S_IDLE) || (go && armed_q)) ? ST_BUSY : status_q;
  assign out    = out_q;
endmodule

// File: tb/tb_probe_table_core.sv
// Directed plus randomized bench for probe_table_core against a slot-array model.
module tb_probe_table_core;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] hash;
  logic [3:0] key, val;
  logic [1:0] cmd;
  logic       go;
  logic [1:0] status;
  logic [3:0] out;

  int total = 0;
  int bad   = 0;

  bit       mv [8];
  bit       mt [8];
  bit [3:0] mk [8];
  bit [3:0] mval [8];
  bit [3:0] mout;

  always #5 clk = ~clk;

  probe_table_core dut (
    .clk(clk), .rst_n(rst_n), .hash(hash), .key(key), .val(val),
    .cmd(cmd), .go(go), .status(status), .out(out)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 0; mt[i] = 0; mk[i] = 0; mval[i] = 0;
    end
    mout = 0;
  endtask

  // Scan the 8 slots from the home index; lat = cycles from accept to result.
  task automatic model_op(input bit [1:0] c, input bit [3:0] k, input bit [3:0] v,
                          input bit [2:0] h, output bit [1:0] st, output int lat);
    int cand = -1;
    int s;
    st  = 2'd1;
    lat = 9;
    if (c == 2'd3) begin
      model_reset();
      st = 2'd0;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      s = (h + i) % 8;
      if (mv[s] && mk[s] == k) begin
        lat = i + 2;
        st  = 2'd0;
        if (c == 2'd0) mout = mval[s];
        if (c == 2'd1) mval[s] = v;
        if (c == 2'd2) begin mv[s] = 0; mt[s] = 1; end
        return;
      end
      if (!mv[s] && cand < 0) cand = s;
      if (!mv[s] && !mt[s]) begin
        lat = i + 2;
        if (c == 2'd1) begin
          mv[cand] = 1; mt[cand] = 0; mk[cand] = k; mval[cand] = v;
          st = 2'd0;
        end else begin
          st = 2'd1;
          if (c == 2'd0) mout = 0;
        end
        return;
      end
    end
    if (c == 2'd1) begin
      if (cand >= 0) begin
        mv[cand] = 1; mt[cand] = 0; mk[cand] = k; mval[cand] = v;
        st = 2'd0;
      end else st = 2'd2;
    end else begin
      st = 2'd1;
      if (c == 2'd0) mout = 0;
    end
  endtask

  task automatic op(input bit [1:0] c, input bit [3:0] k, input bit [3:0] v,
                    input bit [2:0] h, input int hold);
    bit [1:0] est;
    int lat;
    model_op(c, k, v, h, est, lat);
    @(posedge clk); #1;
    cmd = c; key = k; val = v; hash = h; go = 1'b1;
    @(negedge clk);
    chk("busy_c0", status, 4'd3);
    for (int cyc = 1; cyc < lat; cyc++) begin
      @(posedge clk); #1;
      cmd = 2'($urandom); key = 4'($urandom); val = 4'($urandom); hash = 3'($urandom);
      @(negedge clk);
      chk($sformatf("busy_c%0d", cyc), status, 4'd3);
    end
    @(posedge clk); @(negedge clk);
    chk($sformatf("status_op%0d_k%0h", c, k), status, est);
    chk($sformatf("out_op%0d_k%0h", c, k), out, mout);
    for (int j = 0; j < hold; j++) begin
      @(negedge clk);
      chk("hold_status", status, est);
      chk("hold_out", out, mout);
    end
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  initial begin
    bit [1:0] st;
    int lat;
    rst_n = 1'b0; go = 1'b0; cmd = 0; key = 0; val = 0; hash = 0;
    model_reset();
    @(negedge clk);
    chk("rst_status", status, 4'd0);
    chk("rst_out", out, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op(2'd0, 4'd5, 4'd0, 3'd2, 0);
    op(2'd1, 4'd9, 4'hA, 3'd4, 0);
    op(2'd0, 4'd9, 4'd0, 3'd4, 0);

    op(2'd1, 4'd1, 4'd1, 3'd7, 0);
    op(2'd1, 4'd2, 4'd2, 3'd7, 0);
    op(2'd1, 4'd3, 4'd3, 3'd7, 0);
    op(2'd0, 4'd3, 4'd0, 3'd7, 0);

    op(2'd2, 4'd2, 4'd0, 3'd7, 0);
    op(2'd0, 4'd3, 4'd0, 3'd7, 0);
    op(2'd1, 4'd4, 4'd5, 3'd7, 0);
    op(2'd0, 4'd4, 4'd0, 3'd0, 0);

    // A re-triggered delete would flip the held result to BUSY/NOT_FOUND.
    op(2'd2, 4'd4, 4'd0, 3'd0, 4);
    op(2'd0, 4'd4, 4'd0, 3'd0, 0);

    op(2'd3, 4'd0, 4'd0, 3'd0, 0);
    for (int i = 0; i < 8; i++)
      op(2'd1, 4'(i + 1), 4'(15 - i), 3'($urandom), 0);
    op(2'd1, 4'd12, 4'd7, 3'd3, 0);
    op(2'd0, 4'd3, 4'd0, 3'd6, 0);
    op(2'd3, 4'd0, 4'd0, 3'd0, 0);
    op(2'd0, 4'd3, 4'd0, 3'd6, 0);

    // Reset in C3 of an insert: outputs return to reset values asynchronously.
    op(2'd1, 4'hB, 4'h6, 3'd1, 0);
    op(2'd0, 4'hB, 4'd0, 3'd1, 0);
    @(posedge clk); #1;
    cmd = 2'd1; key = 4'hD; val = 4'h9; hash = 3'd1; go = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    #2;
    go = 1'b0; rst_n = 1'b0;
    #1;
    chk("midrst_status", status, 4'd0);
    chk("midrst_out", out, 4'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    op(2'd0, 4'hD, 4'd0, 3'd1, 0);
    op(2'd0, 4'hB, 4'd0, 3'd1, 0);

    for (int n = 0; n < 150; n++) begin
      int r;
      bit [1:0] c;
      r = $urandom_range(0, 39);
      c = (r == 0) ? 2'd3 : 2'(r % 3);
      op(c, 4'($urandom_range(0, 11)), 4'($urandom), 3'($urandom), $urandom_range(0, 2));
    end

    // Fill the table, probe all eight slots repeatedly with misses.
    for (int i = 0; i < 10; i++)
      op(2'd1, 4'($urandom_range(0, 15)), 4'($urandom), 3'($urandom), 0);
    op(2'd0, 4'hF, 4'd0, 3'd5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/probe_table_core.md
# probe_table_core

Linear-probing key/value store that sits directly downstream of the chip-level command front end. It accepts one registered command (lookup, insert, delete, clear) with a 4-bit key, a 4-bit value and a precomputed 3-bit home hash. It walks an 8-slot table one slot per clock, then reports a 2-bit status and a 4-bit read value that the front end drives onto the pads.

## Interface
- No parameters. Depth is fixed at 8 slots, set by the 3-bit hash. Key and value widths are fixed at 4 bits.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low. Clears table, FSM, status and out.
- hash  in  3  home slot index, sampled on accept.
- key  in  4  key, sampled on accept.
- val  in  4  value, sampled on accept. Used by insert only.
- cmd  in  2  0=LOOKUP, 1=INSERT, 2=DELETE, 3=CLEAR. Sampled on accept.
- go  in  1  request strobe, level-held by the front end.
- status  out  2  0=OK, 1=NOT_FOUND, 2=FULL, 3=BUSY.
- out  out  4  value returned by the last LOOKUP.

## Operation
- **Slot contents:** each slot holds valid, tomb, key[3:0] and val[3:0]. Reset and CLEAR set valid=0 and tomb=0 in every slot.
- **FSM states:**
  - IDLE → PROBE on accept (cmd 0-2).
  - IDLE → CLEAR on accept (cmd 3).
  - PROBE → IDLE when the result is decided.
  - CLEAR → IDLE after 8 slots.
- **Accept:** occurs when state=IDLE, go=1 and armed=1.
  - Registers hash, key, val and cmd.
  - Sets armed=0 and probe index p=hash, probe count n=0.
  - armed returns to 1 on any cycle with go=0. A held-high go never re-triggers.
- **PROBE step:** examines slot p once per cycle, then p=p+1 mod 8 (wraps 7→0) and n=n+1.
- **LOOKUP:**
  - valid and key match → status OK, out=slot val.
  - Empty slot (valid=0, tomb=0) → NOT_FOUND, out=0.
  - Tombstone → continue probing.
  - n reaches 8 → NOT_FOUND, out=0.
- **INSERT:**
  - Records the first tombstone or empty slot seen as the candidate.
  - valid and key match → overwrite val, OK.
  - Empty slot → write key/val to the candidate (first free slot seen), set valid=1 and tomb=0, OK.
  - n reaches 8 with no match → write to the candidate if one exists, OK. Otherwise FULL and the table is unchanged.
  - out is unchanged.
- **DELETE:**
  - valid and key match → set valid=0, tomb=1, OK.
  - Empty slot or n reaches 8 → NOT_FOUND.
  - out is unchanged.
- **CLEAR:** zeroes slot p each cycle for 8 cycles, starting at slot 0, then OK. out=0.
- **status output (combinational):** 3 whenever state≠IDLE or (go=1 and armed=1). Otherwise it is the registered result. This ensures the front end sees BUSY on the first cycle its registered go is high.
- **Inputs during an operation:** cmd, key, val and hash changes after accept are ignored until IDLE.

## Timing
- **Reset values:** status=0 (OK), out=0, state=IDLE, armed=1, all slots empty.
- **Cycle numbering:** C0 is the accept cycle; status=3 in C0 via the combinational term. Probe k (k=0..7) occurs in cycle C1+k.
- **Result visibility:** the deciding probe's result is registered at the end of that cycle and is visible on status/out in the next cycle, with state=IDLE.
- **Latency:**
  - Home-slot hit: result in C2.
  - Worst case PROBE: result in C9.
  - CLEAR: result in C9.
- **Table writes:** an insert, delete or clear write takes effect at the same edge that registers the result.
- **go dropped during BUSY:** no effect on the operation, and re-arms.
- **Back-to-back operations:** the earliest next accept is the first IDLE cycle with go=1 after go has been low at least once.
- **Mid-operation reset:** asynchronous. Outputs reach their reset values immediately. Table contents are lost. No partial write survives.

## Test plan
- **Reset, then LOOKUP:** reset, LOOKUP key=5 hash=2 → BUSY through C1, then NOT_FOUND, out=0 in C2.
- **INSERT then LOOKUP, same key:** INSERT key=9 val=0xA hash=4, then LOOKUP key=9 hash=4 → OK, out=0xA, latency 2 cycles.
- **Collision chain with wrap:** INSERT keys 1,2,3 all with hash=7 → placed in slots 7,0,1. LOOKUP key=3 hash=7 → OK in C4.
- **Tombstone reuse:** after the chain above, DELETE key=2 → OK. LOOKUP key=3 → still OK. INSERT key=4 hash=7 → lands in slot 0.
- **Full table:** 8 inserts of distinct keys, then a 9th distinct key → FULL in C9. LOOKUP of an existing key → OK. CLEAR → OK in C9, then any LOOKUP → NOT_FOUND.
- **go handling:**
  - go held high across completion → exactly one operation.
  - rst_n pulsed low in C3 of an INSERT → status=0, out=0 at once, and a later LOOKUP of that key → NOT_FOUND.
